// File: rtl/ad7476_pkg.sv
// Shared definitions for the AD7476 capture block: FSM encoding, frame
// geometry and the half-word packing helper.
package ad7476_pkg;

  // Debug-visible FSM encoding; the values are read back by software.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2,
    WAIT  = 2'd3
  } spi_state_t;

  localparam int FRAME_BITS = 16;  // SCLK rising edges per conversion
  localparam int DATA_BITS  = 12;  // useful sample bits at the LSB end
  localparam int LEAD_BITS  = 4;   // leading bits, always zero from a good ADC

  // One 16-bit half of the output word: a nibble tag above a 12-bit sample.
  function automatic logic [15:0] pack_half(input logic [3:0] tag,
                                            input logic [DATA_BITS-1:0] sample);
    return {tag, sample};
  endfunction

endpackage

// File: rtl/ad7476_sclk_gen.sv
// SCLK generator for the AD7476 frame. While i_run is high, SCLK toggles
// every CLK_DIV clocks starting with a falling edge. o_sclk_rise marks the
// clock edge on which SCLK goes high (the data sampling point) and
// o_frame_done marks the 16th such edge. Dropping i_run parks SCLK high.
module ad7476_sclk_gen
  import ad7476_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_sclk,
  output logic o_sclk_rise,
  output logic o_frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] r_div;
  logic          r_sclk;
  logic [4:0]    r_rise_cnt;
  logic          w_tick;
  logic          w_fall;
  logic          w_rise;

  assign w_tick       = i_run && (r_div == DW'(CLK_DIV - 1));
  assign w_fall       = w_tick && r_sclk;
  assign w_rise       = w_tick && !r_sclk;
  assign o_sclk       = r_sclk;
  assign o_sclk_rise  = w_rise;
  assign o_frame_done = w_rise && (r_rise_cnt == 5'(FRAME_BITS - 1));

  // Half-period divider, SCLK level and rising-edge count for the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_div      <= '0;
      r_sclk     <= 1'b1;
      r_rise_cnt <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      if (w_fall) begin
        r_sclk <= 1'b0;
      end else begin
        r_sclk     <= 1'b1;
        r_rise_cnt <= r_rise_cnt + 5'd1;
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

endmodule

// File: rtl/ad7476_capture.sv
// AD7476 SPI master and sample packer on the Wishbone clock.
// Captures 16-bit frames, keeps the low 12 bits, and pushes two samples per
// 32-bit word. Optional build macro ADC_SEQ_TAG_EN replaces the zero nibbles
// with a per-sample sequence tag.
//
// Push interface: Sensor_RD_Push_o is a one-cycle strobe with no ready; the
// data word is valid in that cycle and held stable until the next strobe.
// A half-filled pair is dropped whenever the FSM returns to IDLE, so every
// new enable session starts pairing from an even sample.
module ad7476_capture #(
  parameter int CLK_DIV       = 2,
  parameter int QUIET_CYCLES  = 4,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        Sensor_Enable_i,
  input  logic        adc_sdata_i,
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  output logic [31:0] Sensor_RD_Data_o,
  output logic        Sensor_RD_Push_o,
  output logic [1:0]  spi_fsm_st_o,
  output logic        frame_err_o
);
  import ad7476_pkg::*;

  spi_state_t            r_state;
  logic                  r_cs_n;
  logic [15:0]           r_period;
  logic [15:0]           r_quiet;
  logic [FRAME_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0]  r_s0;
  logic                  r_ptr;
  logic                  r_abort;
  logic [31:0]           r_data;
  logic                  r_push;
  logic                  r_err;

  logic                  w_sclk;
  logic                  w_sclk_rise;
  logic                  w_frame_done;
  logic                  w_quiet_first;
  logic                  w_store;
  logic                  w_period_up;
  logic [3:0]            w_tag_lo;
  logic [3:0]            w_tag_hi;

  ad7476_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .i_clk       (WBs_CLK_i),
    .i_rst       (WBs_RST_i),
    .i_run       (r_state == CONV),
    .o_sclk      (w_sclk),
    .o_sclk_rise (w_sclk_rise),
    .o_frame_done(w_frame_done)
  );

  // First QUIET cycle: the shift register holds the complete frame.
  assign w_quiet_first = (r_state == QUIET) && (r_quiet == 16'd0);
  assign w_store       = w_quiet_first && !r_abort;
  assign w_period_up   = (r_period >= 16'(SAMPLE_PERIOD - 1));

`ifdef ADC_SEQ_TAG_EN
  logic [3:0] r_tag;
  logic [3:0] r_tag_s0;
  logic       r_en_d;

  // Sequence tag: counts stored samples, restarts on each enable rising edge.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      r_tag    <= 4'h0;
      r_tag_s0 <= 4'h0;
      r_en_d   <= 1'b0;
    end else begin
      r_en_d <= Sensor_Enable_i;
      if (Sensor_Enable_i && !r_en_d) begin
        r_tag <= 4'h0;
      end else if (w_store) begin
        r_tag <= r_tag + 4'h1;
      end
      if (w_store && !r_ptr) begin
        r_tag_s0 <= r_tag;
      end
    end
  end

  assign w_tag_lo = r_tag_s0;
  assign w_tag_hi = r_tag;
`else
  assign w_tag_lo = 4'h0;
  assign w_tag_hi = 4'h0;
`endif

  // Frame sequencing, sample capture, pair packing and error flag.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      r_state  <= IDLE;
      r_cs_n   <= 1'b1;
      r_period <= 16'd0;
      r_quiet  <= 16'd0;
      r_shift  <= '0;
      r_s0     <= '0;
      r_ptr    <= 1'b0;
      r_abort  <= 1'b0;
      r_data   <= 32'd0;
      r_push   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_period != 16'hFFFF) begin
        r_period <= r_period + 16'd1;
      end

      case (r_state)
        IDLE: begin
          if (Sensor_Enable_i) begin
            r_state  <= CONV;
            r_cs_n   <= 1'b0;
            r_period <= 16'd0;
            r_abort  <= 1'b0;
          end
        end

        CONV: begin
          // The ADC needs all 16 clocks, so a dropped enable only marks
          // the frame for discard.
          if (!Sensor_Enable_i) begin
            r_abort <= 1'b1;
          end
          if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], adc_sdata_i};
          end
          if (w_frame_done) begin
            r_state <= QUIET;
            r_cs_n  <= 1'b1;
            r_quiet <= 16'd0;
          end
        end

        QUIET: begin
          if (w_quiet_first) begin
            if (r_shift[FRAME_BITS-1 -: LEAD_BITS] != '0) begin
              r_err <= 1'b1;
            end
            if (r_abort) begin
              r_ptr <= 1'b0;
            end else if (!r_ptr) begin
              r_s0  <= r_shift[DATA_BITS-1:0];
              r_ptr <= 1'b1;
            end else begin
              r_data <= {pack_half(w_tag_hi, r_shift[DATA_BITS-1:0]),
                         pack_half(w_tag_lo, r_s0)};
              r_push <= 1'b1;
              r_ptr  <= 1'b0;
            end
          end
          if (r_quiet == 16'(QUIET_CYCLES - 1)) begin
            r_quiet <= 16'd0;
            if (!Sensor_Enable_i) begin
              r_state <= IDLE;
              r_ptr   <= 1'b0;
            end else if (w_period_up) begin
              r_state  <= CONV;
              r_cs_n   <= 1'b0;
              r_period <= 16'd0;
              r_abort  <= 1'b0;
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_quiet <= r_quiet + 16'd1;
          end
        end

        WAIT: begin
          if (!Sensor_Enable_i) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
          end else if (w_period_up) begin
            r_state  <= CONV;
            r_cs_n   <= 1'b0;
            r_period <= 16'd0;
            r_abort  <= 1'b0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign adc_cs_n_o       = r_cs_n;
  assign adc_sclk_o       = w_sclk;
  assign Sensor_RD_Data_o = r_data;
  assign Sensor_RD_Push_o = r_push;
  assign spi_fsm_st_o     = r_state;
  assign frame_err_o      = r_err;

endmodule

// File: tb/tb_ad7476_capture.sv
// Bench for ad7476_capture: a default-parameter instance plus a fast
// (SAMPLE_PERIOD=20) instance, each fed by a behavioural AD7476 model.
module tb_ad7476_capture;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en = 1'b0;
  logic en_f = 1'b0;
  logic sdata = 1'b0;
  logic sdata_f = 1'b0;

  logic        cs_n, sclk, push, err;
  logic [31:0] data;
  logic [1:0]  st;
  logic        cs_n_f, sclk_f, push_f, err_f;
  logic [31:0] data_f;
  logic [1:0]  st_f;

  int n_run = 0;
  int n_fail = 0;

  ad7476_capture u_dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .Sensor_Enable_i(en), .adc_sdata_i(sdata),
    .adc_cs_n_o(cs_n), .adc_sclk_o(sclk), .Sensor_RD_Data_o(data),
    .Sensor_RD_Push_o(push), .spi_fsm_st_o(st), .frame_err_o(err)
  );

  ad7476_capture #(.SAMPLE_PERIOD(20)) u_fast (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .Sensor_Enable_i(en_f), .adc_sdata_i(sdata_f),
    .adc_cs_n_o(cs_n_f), .adc_sclk_o(sclk_f), .Sensor_RD_Data_o(data_f),
    .Sensor_RD_Push_o(push_f), .spi_fsm_st_o(st_f), .frame_err_o(err_f)
  );

  // ---------------- ADC models ----------------
  // CS_n fall loads the next word and presents its MSB; each SCLK fall
  // presents the next bit (the first fall re-presents the MSB).
  logic [15:0] adc_q[$];
  logic [15:0] adc_q_f[$];
  logic [15:0] cur_w, cur_w_f;
  int adc_bit = 0;
  int adc_bit_f = 0;

  always @(negedge cs_n) begin
    cur_w = (adc_q.size() > 0) ? adc_q.pop_front() : 16'($urandom_range(0, 4095));
    adc_bit = 0;
    sdata = cur_w[15];
  end
  always @(negedge sclk) begin
    if (!cs_n && adc_bit < 16) begin
      sdata = cur_w[15 - adc_bit];
      adc_bit++;
    end
  end
  always @(negedge cs_n_f) begin
    cur_w_f = (adc_q_f.size() > 0) ? adc_q_f.pop_front() : 16'($urandom_range(0, 4095));
    adc_bit_f = 0;
    sdata_f = cur_w_f[15];
  end
  always @(negedge sclk_f) begin
    if (!cs_n_f && adc_bit_f < 16) begin
      sdata_f = cur_w_f[15 - adc_bit_f];
      adc_bit_f++;
    end
  end

  // ---------------- monitors (sampled on the falling clock edge) ----------------
  int cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_cs_f = 1'b1;
  logic [1:0] prev_st = 2'd0;
  int last_fall = 0;
  int frame_rises = 0;
  int fall_q[$];
  int low_q[$];
  int rcnt_q[$];
  int fall_q_f[$];
  int rise_cnt_f = 0;
  logic [1:0] st_q[$];
  logic [31:0] got_q[$];
  logic [31:0] got_q_f[$];

  always @(negedge clk) begin
    cyc++;
    if (!prev_sclk && sclk) frame_rises++;
    if (prev_cs && !cs_n) begin
      fall_q.push_back(cyc);
      last_fall = cyc;
      frame_rises = 0;
    end
    if (!prev_cs && cs_n) begin
      low_q.push_back(cyc - last_fall);
      rcnt_q.push_back(frame_rises);
    end
    if (st != prev_st) st_q.push_back(st);
    if (push) got_q.push_back(data);
    if (prev_cs_f && !cs_n_f) fall_q_f.push_back(cyc);
    if (!prev_cs_f && cs_n_f) rise_cnt_f++;
    if (push_f) got_q_f.push_back(data_f);
    prev_cs = cs_n;
    prev_sclk = sclk;
    prev_st = st;
    prev_cs_f = cs_n_f;
  end

  // ---------------- reference model ----------------
  // A pair of kept samples s0,s1 becomes one word; tags count kept samples
  // from the last enable rising edge.
  function automatic logic [31:0] exp_pair(input logic [11:0] s0, input logic [11:0] s1,
                                           input logic [3:0] t);
    logic [3:0] th;
    th = t + 4'd1;
`ifdef ADC_SEQ_TAG_EN
    return {th, s1, t, s0};
`else
    return {4'h0, s1, 4'h0, s0};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    en_f = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    adc_q.delete(); adc_q_f.delete();
    fall_q.delete(); low_q.delete(); rcnt_q.delete(); st_q.delete();
    got_q.delete(); got_q_f.delete(); fall_q_f.delete();
    rise_cnt_f = 0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300 && st !== 2'd0; k++) @(negedge clk);
    n_run++;
    if (st !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_idle state=%0d expected 0", name, st);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_run++;
    if ({cs_n, sclk, data, push, st, err} !== {1'b1, 1'b1, 32'h0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_main cs=%b sclk=%b data=%h push=%b st=%0d err=%b expected 1 1 0 0 0 0",
               cs_n, sclk, data, push, st, err);
    end
    n_run++;
    if ({cs_n_f, sclk_f, data_f, push_f, st_f, err_f} !== {1'b1, 1'b1, 32'h0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_fast cs=%b sclk=%b data=%h push=%b st=%0d err=%b expected 1 1 0 0 0 0",
               cs_n_f, sclk_f, data_f, push_f, st_f, err_f);
    end
  endtask

  task automatic test_basic_pair();
    int k;
    do_reset();
    adc_q.push_back(16'h0ABC);
    adc_q.push_back(16'h0123);
    en = 1'b1;
    for (k = 0; k < 400 && got_q.size() < 1; k++) @(negedge clk);
    n_run++;
    if (got_q.size() < 1) begin
      n_fail++;
      $display("FAIL basic_push pushes=0 expected 1");
    end else if (got_q[0] !== exp_pair(12'hABC, 12'h123, 4'h0)) begin
      n_fail++;
      $display("FAIL basic_data got=%h expected %h", got_q[0], exp_pair(12'hABC, 12'h123, 4'h0));
    end
    n_run++;
    if (st_q.size() < 4 || {st_q[0], st_q[1], st_q[2], st_q[3]} !== 8'b01_10_11_01) begin
      n_fail++;
      $display("FAIL basic_states n=%0d expected sequence 1,2,3,1", st_q.size());
    end
    n_run++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err got=%b expected 0", err);
    end
    en = 1'b0;
    wait_idle("basic");
  endtask

  task automatic test_throughput();
    logic [11:0] w[10];
    int k;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      w[i] = 12'($urandom_range(0, 4095));
      adc_q.push_back({4'h0, w[i]});
    end
    en = 1'b1;
    for (k = 0; k < 1500 && low_q.size() < 10; k++) @(negedge clk);
    en = 1'b0;
    repeat (150) @(negedge clk);
    n_run++;
    if (got_q.size() != 5) begin
      n_fail++;
      $display("FAIL thru_count pushes=%0d expected 5", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_run++;
      if (got_q[i] !== exp_pair(w[2*i], w[2*i+1], 4'(2*i))) begin
        n_fail++;
        $display("FAIL thru_data[%0d] got=%h expected %h", i, got_q[i],
                 exp_pair(w[2*i], w[2*i+1], 4'(2*i)));
      end
    end
    n_run++;
    if (fall_q.size() != 10) begin
      n_fail++;
      $display("FAIL thru_frames falls=%0d expected 10", fall_q.size());
    end
    for (int i = 1; i < fall_q.size(); i++) begin
      n_run++;
      if (fall_q[i] - fall_q[i-1] != 100) begin
        n_fail++;
        $display("FAIL thru_period[%0d] got=%0d expected 100", i, fall_q[i] - fall_q[i-1]);
      end
    end
    for (int i = 0; i < low_q.size(); i++) begin
      n_run++;
      if (low_q[i] != 64 || rcnt_q[i] != 16) begin
        n_fail++;
        $display("FAIL thru_frame[%0d] cs_low=%0d rises=%0d expected 64 16", i, low_q[i], rcnt_q[i]);
      end
    end
    wait_idle("thru");
  endtask

  task automatic test_back_to_back();
    logic [11:0] w[6];
    int k;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w[i] = 12'($urandom_range(0, 4095));
      adc_q_f.push_back({4'h0, w[i]});
    end
    en_f = 1'b1;
    for (k = 0; k < 1000 && rise_cnt_f < 6; k++) @(negedge clk);
    en_f = 1'b0;
    repeat (40) @(negedge clk);
    n_run++;
    if (fall_q_f.size() != 6 || got_q_f.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count falls=%0d pushes=%0d expected 6 3", fall_q_f.size(), got_q_f.size());
    end
    for (int i = 1; i < fall_q_f.size(); i++) begin
      n_run++;
      if (fall_q_f[i] - fall_q_f[i-1] != 68) begin
        n_fail++;
        $display("FAIL b2b_period[%0d] got=%0d expected 68", i, fall_q_f[i] - fall_q_f[i-1]);
      end
    end
    for (int i = 0; i < 3 && i < got_q_f.size(); i++) begin
      n_run++;
      if (got_q_f[i] !== exp_pair(w[2*i], w[2*i+1], 4'(2*i))) begin
        n_fail++;
        $display("FAIL b2b_data[%0d] got=%h expected %h", i, got_q_f[i],
                 exp_pair(w[2*i], w[2*i+1], 4'(2*i)));
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [11:0] a0, a1, a2;
    int k;
    do_reset();
    a0 = 12'($urandom_range(0, 4095));
    a1 = 12'($urandom_range(0, 4095));
    a2 = 12'($urandom_range(0, 4095));
    adc_q.push_back({4'h0, a0});
    adc_q.push_back({4'h0, a1});
    adc_q.push_back({4'h0, a2});
    en = 1'b1;
    for (k = 0; k < 200 && !(fall_q.size() >= 1 && frame_rises >= 8); k++) @(negedge clk);
    en = 1'b0;
    wait_idle("drop");
    n_run++;
    if (rcnt_q.size() < 1 || rcnt_q[0] != 16) begin
      n_fail++;
      $display("FAIL drop_rises frames=%0d expected one frame with 16 rises", rcnt_q.size());
    end
    n_run++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL drop_push pushes=%0d expected 0", got_q.size());
    end
    repeat (5) @(negedge clk);
    en = 1'b1;
    for (k = 0; k < 400 && got_q.size() < 1; k++) @(negedge clk);
    n_run++;
    if (got_q.size() < 1 || got_q[0] !== exp_pair(a1, a2, 4'h0)) begin
      n_fail++;
      $display("FAIL drop_realign pushes=%0d first=%h expected %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 32'h0, exp_pair(a1, a2, 4'h0));
    end
    en = 1'b0;
    wait_idle("drop_end");
  endtask

  task automatic test_frame_err();
    int k;
    do_reset();
    adc_q.push_back(16'hF123);
    adc_q.push_back(16'h0456);
    en = 1'b1;
    for (k = 0; k < 200 && low_q.size() < 1; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_run++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got=%b expected 1", err);
    end
    for (k = 0; k < 300 && got_q.size() < 1; k++) @(negedge clk);
    n_run++;
    if (got_q.size() < 1 || got_q[0] !== exp_pair(12'h123, 12'h456, 4'h0)) begin
      n_fail++;
      $display("FAIL err_data pushes=%0d expected word %h", got_q.size(), exp_pair(12'h123, 12'h456, 4'h0));
    end
    n_run++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%b expected 1", err);
    end
    for (k = 0; k < 200 && cs_n !== 1'b0; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_run++;
    if ({cs_n, sclk, data, push, st, err} !== {1'b1, 1'b1, 32'h0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL err_reset cs=%b sclk=%b data=%h push=%b st=%0d err=%b expected 1 1 0 0 0 0",
               cs_n, sclk, data, push, st, err);
    end
    rst = 1'b0;
    en = 1'b0;
    got_q.delete();
    repeat (150) @(negedge clk);
    n_run++;
    if (got_q.size() != 0 || st !== 2'd0) begin
      n_fail++;
      $display("FAIL err_abort pushes=%0d state=%0d expected 0 0", got_q.size(), st);
    end
  endtask

  task automatic test_pair_sequence();
    logic [31:0] exp0, exp1;
    int k;
    do_reset();
`ifdef ADC_SEQ_TAG_EN
    exp0 = 32'h1BBB0AAA;
    exp1 = 32'h3DDD2CCC;
`else
    exp0 = 32'h0BBB0AAA;
    exp1 = 32'h0DDD0CCC;
`endif
    adc_q.push_back(16'h0AAA);
    adc_q.push_back(16'h0BBB);
    adc_q.push_back(16'h0CCC);
    adc_q.push_back(16'h0DDD);
    en = 1'b1;
    for (k = 0; k < 800 && got_q.size() < 2; k++) @(negedge clk);
    en = 1'b0;
    n_run++;
    if (got_q.size() < 2 || got_q[0] !== exp0 || got_q[1] !== exp1) begin
      n_fail++;
      $display("FAIL seq_pairs pushes=%0d first=%h second=%h expected %h %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 32'h0, (got_q.size() > 1) ? got_q[1] : 32'h0,
               exp0, exp1);
    end
    wait_idle("seq");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_pair();
    test_throughput();
    test_back_to_back();
    test_enable_drop();
    test_frame_err();
    test_pair_sequence();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
